// File: rtl/regs_write_arbiter.sv
// ---------------------------------------------------------------------------
// regs_write_arbiter : round-robin arbiter with lockable bursts for the Special Regs write port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regs_write_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 8,
  parameter int MAX_BURST     = 8,
  parameter int LOCK_IDLE_MAX = 16,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ-1:0]         i_req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_regs_write_en,
  output logic [ADDR_W-1:0]          o_regs_addr,
  output logic [DATA_W-1:0]          o_regs_write_data,
  output logic                       o_grant_valid,
  output logic [ID_W-1:0]            o_grant_id,
  output logic                       o_lock_abort
);

  localparam int IDX_W = ID_W + 1;
  localparam logic [7:0] c_burst_last = 8'(MAX_BURST - 1);
  localparam logic [7:0] c_idle_last  = 8'(LOCK_IDLE_MAX - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [ID_W-1:0]     r_owner, w_owner_nxt;
  logic [ID_W-1:0]     r_rr_ptr, w_rr_nxt;
  logic [7:0]          r_burst_cnt, w_burst_nxt;
  logic [7:0]          r_idle_cnt, w_idle_nxt;
  logic                r_wen, w_wen_nxt;
  logic                r_abort, w_abort_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_data, w_data_nxt;

  logic                w_pick_found;
  logic [ID_W-1:0]     w_pick_id;
  logic [IDX_W-1:0]    w_scan_idx;
  logic                w_own_valid;
  logic                w_own_lock;
  logic [ADDR_W-1:0]   w_own_addr;
  logic [DATA_W-1:0]   w_own_data;
  logic [ID_W-1:0]     w_owner_inc;
  logic [NUM_REQ-1:0]  w_ready;
  logic                w_release;

  // Round-robin scan: first requester at or after r_rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_id    = '0;
    w_scan_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + IDX_W'(k);
      if (w_scan_idx >= IDX_W'(NUM_REQ)) begin
        w_scan_idx = w_scan_idx - IDX_W'(NUM_REQ);
      end
      if (!w_pick_found && i_req_valid[w_scan_idx[ID_W-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_id    = w_scan_idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_own_valid = 1'b0;
    w_own_lock  = 1'b0;
    w_own_addr  = '0;
    w_own_data  = '0;
    w_ready     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == ID_W'(i)) begin
        w_own_valid = i_req_valid[i];
        w_own_lock  = i_req_lock[i];
        w_own_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
        w_own_data  = i_req_data[i*DATA_W +: DATA_W];
        w_ready[i]  = (r_state == S_OWNED) && i_req_valid[i];
      end
    end
  end

  assign w_owner_inc = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + ID_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rr_nxt    = r_rr_ptr;
    w_burst_nxt = r_burst_cnt;
    w_idle_nxt  = r_idle_cnt;
    w_wen_nxt   = 1'b0;
    w_abort_nxt = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = S_OWNED;
          w_owner_nxt = w_pick_id;
          w_burst_nxt = '0;
          w_idle_nxt  = '0;
        end
      end
      S_OWNED: begin
        if (w_own_valid) begin
          w_wen_nxt   = 1'b1;
          w_addr_nxt  = w_own_addr;
          w_data_nxt  = w_own_data;
          w_burst_nxt = r_burst_cnt + 8'd1;
          w_idle_nxt  = '0;
          if (!w_own_lock) begin
            w_release = 1'b1;
          end else if (r_burst_cnt == c_burst_last) begin
            w_release   = 1'b1;
            w_abort_nxt = 1'b1;
          end
        end else begin
          // Owner withdrew without lock, or lock held too long with nothing to send.
          if (!w_own_lock) begin
            w_release = 1'b1;
          end else if (r_idle_cnt == c_idle_last) begin
            w_release   = 1'b1;
            w_abort_nxt = 1'b1;
          end else begin
            w_idle_nxt = r_idle_cnt + 8'd1;
          end
        end
        if (w_release) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = w_owner_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
      r_wen       <= 1'b0;
      r_abort     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_idle_cnt  <= w_idle_nxt;
      r_wen       <= w_wen_nxt;
      r_abort     <= w_abort_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
    end
  end

  assign o_req_ready       = w_ready;
  assign o_regs_write_en   = r_wen;
  assign o_regs_addr       = r_addr;
  assign o_regs_write_data = r_data;
  assign o_grant_valid     = (r_state == S_OWNED);
  assign o_grant_id        = (r_state == S_OWNED) ? r_owner : '0;
  assign o_lock_abort      = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_regs_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regs_write_arbiter : directed scenarios plus randomized traffic against a behavioural model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regs_write_arbiter;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int MB  = 8;
  localparam int LIM = 16;
  localparam int IW  = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]    ready;
  logic            wen;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            gv;
  logic [IW-1:0]   gid;
  logic            abort;

  always #5 clk = ~clk;

  regs_write_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .LOCK_IDLE_MAX(LIM)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(valid), .i_req_lock(lock), .i_req_addr(addr), .i_req_data(data),
    .o_req_ready(ready), .o_regs_write_en(wen), .o_regs_addr(waddr),
    .o_regs_write_data(wdata), .o_grant_valid(gv), .o_grant_id(gid), .o_lock_abort(abort)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 25) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the port, where the next scan starts, how long the burst/idle run is.
  bit            m_owned;
  int            m_owner, m_rr, m_beats, m_idle;
  bit            m_wen, m_abort;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic void model_reset();
    m_owned = 0; m_owner = 0; m_rr = 0; m_beats = 0; m_idle = 0;
    m_wen = 0; m_abort = 0; m_addr = '0; m_data = '0;
  endfunction

  function automatic void model_step();
    bit nw = 0, na = 0, rel = 0, found = 0;
    if (!m_owned) begin
      for (int k = 0; k < N; k++) begin
        int c = (m_rr + k) % N;
        if (!found && valid[c]) begin
          found = 1; m_owned = 1; m_owner = c; m_beats = 0; m_idle = 0;
        end
      end
    end else begin
      int o = m_owner;
      if (valid[o]) begin
        nw = 1;
        m_addr = addr[o*AW +: AW];
        m_data = data[o*DW +: DW];
        m_beats++;
        m_idle = 0;
        if (!lock[o]) rel = 1;
        else if (m_beats == MB) begin rel = 1; na = 1; end
      end else begin
        m_idle++;
        if (!lock[o]) rel = 1;
        else if (m_idle == LIM) begin rel = 1; na = 1; end
      end
      if (rel) begin m_owned = 0; m_rr = (o + 1) % N; end
    end
    m_wen = nw;
    m_abort = na;
  endfunction

  logic [N-1:0]  obs_ready;
  logic          obs_wen, obs_gv, obs_abort;
  logic [IW-1:0] obs_gid;
  logic [AW-1:0] obs_addr;
  logic [DW-1:0] obs_data;

  // One clock: compare at the falling edge, advance the model on the rising edge.
  task automatic step();
    logic [N-1:0] er;
    @(negedge clk);
    obs_ready = ready; obs_wen = wen; obs_gv = gv; obs_gid = gid;
    obs_abort = abort; obs_addr = waddr; obs_data = wdata;
    er = '0;
    if (m_owned && valid[m_owner]) er[m_owner] = 1'b1;
    chk("ready", ready, er);
    chk("grant_valid", gv, m_owned);
    chk("grant_id", gid, m_owned ? m_owner : 0);
    chk("write_en", wen, m_wen);
    chk("regs_addr", waddr, m_addr);
    chk("regs_data", wdata, m_data);
    chk("lock_abort", abort, m_abort);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; valid = '0; lock = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] pat;
    logic [AW-1:0] exp_addrs [4];
    int n, beats, strobes, first_s, last_s, g2, abort_at, aborts, own3, ab_cyc, g1;
    int mode;

    model_reset();
    #1;
    chk("rst_write_en", wen, 0);
    chk("rst_grant_valid", gv, 0);
    chk("rst_ready", ready, 0);
    chk("rst_abort", abort, 0);
    chk("rst_addr", waddr, 0);
    do_reset();

    // Single unlocked write from requester 0.
    valid = 4'b0001; addr[7:0] = 8'h10; data[7:0] = 8'hAB;
    step(); chk("t1_c0_grant", obs_gv, 0);
    step(); chk("t1_c1_grant", obs_gv, 1); chk("t1_c1_ready", obs_ready, 4'b0001);
    valid = '0;
    step(); chk("t1_c2_wen", obs_wen, 1); chk("t1_c2_addr", obs_addr, 8'h10);
    chk("t1_c2_data", obs_data, 8'hAB); chk("t1_c2_idle", obs_gv, 0);

    // Three requesters, no lock: 0,1,2 then wrap back to 0 with dead cycles.
    do_reset();
    valid = 4'b0111; addr = 32'h00222120;
    pat = 9'b010101010; n = 0;
    exp_addrs[0] = 8'h20; exp_addrs[1] = 8'h21; exp_addrs[2] = 8'h22; exp_addrs[3] = 8'h20;
    for (int c = 0; c < 9; c++) begin
      step();
      chk("t2_gv_pattern", obs_gv, pat[c]);
      if (obs_wen && n < 4) begin chk("t2_order", obs_addr, exp_addrs[n]); n++; end
    end
    chk("t2_strobes", n, 4);

    // Locked six-beat burst from requester 1 with requester 2 waiting.
    do_reset();
    valid = 4'b0110; lock = 4'b0010;
    addr[15:8] = 8'h30; data[15:8] = 8'hC0; addr[23:16] = 8'h50; data[23:16] = 8'h55;
    beats = 0; n = 0; first_s = -1; last_s = -1; g2 = -1;
    for (int c = 0; c < 40 && g2 < 0; c++) begin
      step();
      if (obs_wen && obs_addr >= 8'h30 && obs_addr <= 8'h35) begin
        chk("t3_addr", obs_addr, 8'h30 + n[7:0]);
        n++;
        if (first_s < 0) first_s = c;
        last_s = c;
      end
      if (obs_gv && obs_gid == 2 && g2 < 0) g2 = c;
      if (obs_ready[1]) begin
        beats++;
        addr[15:8] = 8'h30 + beats[7:0]; data[15:8] = 8'hC0 + beats[7:0];
        if (beats == 5) lock[1] = 1'b0;
        if (beats == 6) valid[1] = 1'b0;
      end
    end
    chk("t3_beats", n, 6);
    chk("t3_first_strobe", first_s, 2);
    chk("t3_last_strobe", last_s, 7);
    chk("t3_req2_grant", g2, 8);

    // Requester 0 holds lock over 12 beats; cap forces release at beat 8.
    do_reset();
    valid = 4'b0001; lock = 4'b0001;
    beats = 0; strobes = 0; abort_at = -1; aborts = 0;
    for (int c = 0; c < 60 && strobes < 12; c++) begin
      step();
      if (obs_wen) strobes++;
      if (obs_abort) begin aborts++; if (abort_at < 0) abort_at = strobes; end
      if (obs_ready[0]) begin
        beats++;
        addr[7:0] = beats[7:0];
        if (beats == 11) lock[0] = 1'b0;
        if (beats == 12) valid[0] = 1'b0;
      end
    end
    chk("t4_strobes", strobes, 12);
    chk("t4_abort_on_strobe", abort_at, 8);
    chk("t4_abort_count", aborts, 1);

    // Requester 3 locks but goes quiet; idle timer releases it to requester 1.
    do_reset();
    valid = 4'b1000; lock = 4'b1000;
    step();
    valid = 4'b0010;
    own3 = 0; ab_cyc = -1; g1 = -1;
    for (int c = 0; c < 60 && g1 < 0; c++) begin
      step();
      if (obs_gv && obs_gid == 3) own3++;
      if (obs_abort && ab_cyc < 0) ab_cyc = c;
      if (obs_gv && obs_gid == 1) g1 = c;
    end
    chk("t5_owned_cycles", own3, 16);
    chk("t5_abort_cycle", ab_cyc, 16);
    chk("t5_req1_grant", g1, 17);

    // Reset arriving mid-burst drops everything at once.
    do_reset();
    valid = 4'b0100; lock = 4'b0100;
    beats = 0;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      step();
      if (obs_ready[2]) beats++;
    end
    chk("t6_pre_wen", wen, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_wen_drop", wen, 0);
    chk("t6_gv_drop", gv, 0);
    chk("t6_ready_drop", ready, 0);
    model_reset();
    valid = '0; lock = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    valid = 4'b1111;
    step();
    step();
    chk("t6_first_gv", obs_gv, 1);
    chk("t6_first_gid", obs_gid, 0);

    // Randomized traffic in three moods: busy, sparse, and quiet-but-locked.
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: begin valid[i] = ($urandom_range(0, 99) < 80); lock[i] = ($urandom_range(0, 99) < 60); end
          1: begin valid[i] = ($urandom_range(0, 99) < 30); lock[i] = ($urandom_range(0, 99) < 40); end
          default: begin valid[i] = ($urandom_range(0, 99) < 8); lock[i] = ($urandom_range(0, 99) < 97); end
        endcase
      end
      addr = $urandom;
      data = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
